// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised rx line, oversampled start-bit qualification,
// LSB-first data, optional parity, one stop bit, one-clock rx_done strobe.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic          ODD    = (PARITY_ODD != 0);
    localparam logic          PAR_ON = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rx_s;
    logic                   rx_s_d;
    logic [SW-1:0]          s_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   parity_bit;
    logic                   fall;

    // Synchroniser flops reset to the idle-high line level so reset never fakes a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    assign fall = rx_s_d && !rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            s_cnt      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            rx_data    <= '0;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall) begin
                        state   <= START;
                        s_cnt   <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end

                // Qualify the start bit at its centre; every later sample lands mid-bit.
                START: begin
                    if (tick) begin
                        if (s_cnt == S_HALF) begin
                            s_cnt <= '0;
                            if (!rx_s) begin
                                state <= DATA;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (s_cnt == S_LAST) begin
                            s_cnt <= '0;
                            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                            if (bit_cnt == B_LAST) begin
                                bit_cnt <= '0;
                                state   <= PAR_ON ? PARITY : STOP;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end

                PARITY: begin
                    if (tick) begin
                        if (s_cnt == S_LAST) begin
                            s_cnt      <= '0;
                            parity_bit <= rx_s;
                            state      <= STOP;
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end

                // Returning to IDLE at mid-stop lets a back-to-back start edge be caught.
                STOP: begin
                    if (tick) begin
                        if (s_cnt == S_LAST) begin
                            s_cnt      <= '0;
                            rx_data    <= shreg;
                            rx_done    <= 1'b1;
                            frame_err  <= ~rx_s;
                            parity_err <= PAR_ON && (((^shreg) ^ parity_bit) != ODD);
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    s_cnt <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: an 8N1 instance and an 8E1 instance share clock,
// reset and tick; expected frames are queued at send time and checked on rx_done.
module tb_uart_rx;

    localparam int TICK_DIV = 8;
    localparam int BIT_CLK  = 16 * TICK_DIV;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       rx0;
    logic       rx1;
    logic [7:0] rx_data0;
    logic       rx_done0;
    logic       frame_err0;
    logic       parity_err0;
    logic       busy0;
    logic [7:0] rx_data1;
    logic       rx_done1;
    logic       frame_err1;
    logic       parity_err1;
    logic       busy1;

    int   tests = 0;
    int   fails = 0;
    exp_t q0[$];
    exp_t q1[$];

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .tick(tick), .rx(rx0),
        .rx_data(rx_data0), .rx_done(rx_done0), .frame_err(frame_err0),
        .parity_err(parity_err0), .busy(busy0)
    );

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_par (
        .clk(clk), .rst(rst), .tick(tick), .rx(rx1),
        .rx_data(rx_data1), .rx_done(rx_done1), .frame_err(frame_err1),
        .parity_err(parity_err1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick is a one-clock pulse every TICK_DIV clocks, changed on the falling edge.
    initial begin
        int cnt;
        cnt  = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            cnt  = (cnt == TICK_DIV - 1) ? 0 : cnt + 1;
            tick = (cnt == TICK_DIV - 1);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic driveBit(input int which, input logic v);
        if (which == 0) rx0 = v;
        else            rx1 = v;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic applyStimulus(input int which, input logic [7:0] data, input logic pbit,
                                 input logic stop, input logic exp_ferr, input logic exp_perr);
        exp_t e;
        e.data = data;
        e.ferr = exp_ferr;
        e.perr = exp_perr;
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
        driveBit(which, 1'b0);
        for (int i = 0; i < 8; i++) driveBit(which, data[i]);
        if (which == 1) driveBit(which, pbit);
        driveBit(which, stop);
        if (which == 0) rx0 = 1'b1;
        else            rx1 = 1'b1;
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 4 * BIT_CLK && (q0.size() + q1.size()) > 0; i++) @(negedge clk);
        checkOutput(name, 32'(q0.size() + q1.size()), 32'd0);
    endtask

    // Monitors: pop one expected frame per rx_done cycle; an extra cycle finds an empty queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rx_done0 === 1'b1) begin
                if (q0.size() == 0) begin
                    checkOutput("dut spurious rx_done", 32'd1, 32'd0);
                end else begin
                    e = q0.pop_front();
                    checkOutput("dut rx_data", 32'(rx_data0), 32'(e.data));
                    checkOutput("dut frame_err", 32'(frame_err0), 32'(e.ferr));
                    checkOutput("dut parity_err", 32'(parity_err0), 32'(e.perr));
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rx_done1 === 1'b1) begin
                if (q1.size() == 0) begin
                    checkOutput("dut_par spurious rx_done", 32'd1, 32'd0);
                end else begin
                    e = q1.pop_front();
                    checkOutput("dut_par rx_data", 32'(rx_data1), 32'(e.data));
                    checkOutput("dut_par frame_err", 32'(frame_err1), 32'(e.ferr));
                    checkOutput("dut_par parity_err", 32'(parity_err1), 32'(e.perr));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        rx0 = 1'b1;
        rx1 = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("reset rx_data", 32'(rx_data0), 32'h00);
        checkOutput("reset rx_done", 32'(rx_done0), 32'd0);
        checkOutput("reset frame_err", 32'(frame_err0), 32'd0);
        checkOutput("reset parity_err", 32'(parity_err0), 32'd0);
        checkOutput("reset busy", 32'(busy0), 32'd0);
        rst = 1'b0;
        repeat (BIT_CLK) @(negedge clk);

        applyStimulus(0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        waitDrain("A5 delivered");
        repeat (4) @(negedge clk);
        checkOutput("A5 busy after", 32'(busy0), 32'd0);

        // Short low pulse: start qualified at half-bit fails, receiver goes idle.
        rx0 = 1'b0;
        repeat (3 * TICK_DIV) @(negedge clk);
        checkOutput("glitch busy high", 32'(busy0), 32'd1);
        rx0 = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        checkOutput("glitch busy low", 32'(busy0), 32'd0);
        checkOutput("glitch rx_data held", 32'(rx_data0), 32'hA5);

        applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        waitDrain("3C bad stop delivered");
        repeat (2 * BIT_CLK) @(negedge clk);
        checkOutput("frame_err held", 32'(frame_err0), 32'd1);
        applyStimulus(0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        waitDrain("3C good stop delivered");
        repeat (BIT_CLK) @(negedge clk);

        applyStimulus(1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        waitDrain("07 parity ok delivered");
        repeat (BIT_CLK) @(negedge clk);
        applyStimulus(1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b1);
        waitDrain("07 parity bad delivered");
        repeat (BIT_CLK) @(negedge clk);

        // Reset after the fourth data bit of 0x5A (LSB first: 0,1,0,1).
        driveBit(0, 1'b0);
        driveBit(0, 1'b0);
        driveBit(0, 1'b1);
        driveBit(0, 1'b0);
        driveBit(0, 1'b1);
        checkOutput("midframe busy before rst", 32'(busy0), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midframe rst busy", 32'(busy0), 32'd0);
        checkOutput("midframe rst rx_data", 32'(rx_data0), 32'h00);
        checkOutput("midframe rst rx_done", 32'(rx_done0), 32'd0);
        checkOutput("midframe rst frame_err", 32'(frame_err0), 32'd0);
        checkOutput("midframe rst parity_err", 32'(parity_err1), 32'd0);
        rx0 = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        applyStimulus(0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        waitDrain("5A after reset delivered");
        repeat (BIT_CLK) @(negedge clk);

        applyStimulus(0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
        waitDrain("back-to-back delivered");
        repeat (BIT_CLK) @(negedge clk);
        checkOutput("final rx_data", 32'(rx_data0), 32'hFF);
        checkOutput("final busy", 32'(busy0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
